// File: rtl/spi_dev_memrd_if.sv
// rtl/spi_dev_memrd_if.sv - protocol-wrapper and memory-request signal bundle for spi_dev_memrd
interface spi_dev_memrd_if #(
  parameter int ADDR_WIDTH = 23
);
  // protocol wrapper, host -> device bytes
  logic [7:0]            pw_wdata;
  logic                  pw_wcmd;
  logic                  pw_wstb;
  logic                  pw_end;
  // protocol wrapper, device -> host response path
  logic                  pw_req;
  logic                  pw_gnt;
  logic [7:0]            pw_rdata;
  logic                  pw_rstb;
  // memory-controller request channel
  logic [ADDR_WIDTH-1:0] mi_addr;
  logic [6:0]            mi_len;
  logic                  mi_rw;
  logic                  mi_valid;
  logic                  mi_ready;
  // memory-controller read-data channel
  logic [15:0]           mi_rdata;
  logic                  mi_rstb;
  logic                  mi_rlast;
  // status
  logic                  underrun;

  modport slave (
    input  pw_wdata, pw_wcmd, pw_wstb, pw_end, pw_gnt,
    input  mi_ready, mi_rdata, mi_rstb, mi_rlast,
    output pw_req, pw_rdata, pw_rstb,
    output mi_addr, mi_len, mi_rw, mi_valid,
    output underrun
  );

  modport master (
    output pw_wdata, pw_wcmd, pw_wstb, pw_end, pw_gnt,
    output mi_ready, mi_rdata, mi_rstb, mi_rlast,
    input  pw_req, pw_rdata, pw_rstb,
    input  mi_addr, mi_len, mi_rw, mi_valid,
    input  underrun
  );
endinterface

// File: rtl/spi_dev_memrd.sv
// rtl/spi_dev_memrd.sv - SPI-command-driven PSRAM read streamer with burst prefetch FIFO
module spi_dev_memrd #(
  parameter logic [7:0] CMD_BYTE   = 8'he1,
  parameter int         ADDR_WIDTH = 23,
  parameter int         FIFO_DEPTH = 32,
  parameter int         BURST_LEN  = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_dev_memrd_if.slave bus
);

  localparam int CW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ADDR   = 2'd1,
    S_STREAM = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t                state_q;
  logic [1:0]            abyte_q;     // address bytes received so far
  logic [15:0]           abuf_q;      // first two (most significant) address bytes
  logic [ADDR_WIDTH-1:0] addr_q;      // next burst word address, driven on mi_addr
  logic                  phase_q;     // 0: next byte is high byte of head word, 1: low byte
  logic                  mi_valid_q;
  logic                  burst_q;     // a burst has been accepted and has not seen rlast
  logic                  pw_req_q;
  logic                  pw_rstb_q;
  logic [7:0]            pw_rdata_q;
  logic                  underrun_q;

  logic [15:0]           fifo_mem [FIFO_DEPTH];
  logic [CW-1:0]         wr_ptr_q;
  logic [CW-1:0]         rd_ptr_q;
  logic [CW:0]           count_q;

  logic                  data_stb_d;
  logic                  cmd_stb_d;
  logic                  rd_cmd_d;
  logic                  rlast_d;
  logic                  accept_d;
  logic                  busy_d;
  logic                  abort_d;
  logic                  push_d;
  logic                  pop_d;
  logic                  empty_d;
  logic                  pop_word_d;
  logic                  free_ok_d;
  logic [15:0]           head_d;
  logic [7:0]            head_byte_d;
  logic [ADDR_WIDTH:0]   start_d;

  assign data_stb_d  = bus.pw_wstb & ~bus.pw_wcmd;
  assign cmd_stb_d   = bus.pw_wstb &  bus.pw_wcmd;
  assign rd_cmd_d    = cmd_stb_d & (bus.pw_wdata == CMD_BYTE);
  assign rlast_d     = bus.mi_rstb & bus.mi_rlast;
  assign accept_d    = mi_valid_q & bus.mi_ready;

  // A burst still owes us data if it was outstanding and this is not its last
  // word, or if it is being accepted right now.
  assign busy_d      = (burst_q & ~rlast_d) | accept_d;

  // Transaction end or any command byte terminates an open read session.
  assign abort_d     = ((state_q == S_ADDR) || (state_q == S_STREAM)) &
                       (bus.pw_end | cmd_stb_d);

  assign push_d      = (state_q == S_STREAM) & bus.mi_rstb & ~abort_d;
  assign pop_d       = (state_q == S_STREAM) & data_stb_d & bus.pw_gnt & ~abort_d;
  assign empty_d     = (count_q == '0);
  assign pop_word_d  = pop_d & ~empty_d & phase_q;
  assign free_ok_d   = (((CW+1)'(FIFO_DEPTH)) - count_q) >= (CW+1)'(BURST_LEN);

  assign head_d      = fifo_mem[rd_ptr_q];
  assign head_byte_d = phase_q ? head_d[7:0] : head_d[15:8];

  // Byte address is 24 bits big-endian; the word address drops bit 0.
  assign start_d     = (ADDR_WIDTH+1)'({abuf_q, bus.pw_wdata});

  assign bus.pw_req   = pw_req_q;
  assign bus.pw_rdata = pw_rdata_q;
  assign bus.pw_rstb  = pw_rstb_q;
  assign bus.mi_addr  = addr_q;
  assign bus.mi_len   = 7'(BURST_LEN - 1);
  assign bus.mi_rw    = 1'b1;
  assign bus.mi_valid = mi_valid_q;
  assign bus.underrun = underrun_q;

  // Prefetch FIFO storage; pointers and occupancy live with the FSM below.
  always_ff @(posedge clk) begin
    if (push_d) begin
      fifo_mem[wr_ptr_q] <= bus.mi_rdata;
    end
  end

  // Session FSM, burst tracking, FIFO bookkeeping and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      abyte_q    <= '0;
      abuf_q     <= '0;
      addr_q     <= '0;
      phase_q    <= 1'b0;
      mi_valid_q <= 1'b0;
      burst_q    <= 1'b0;
      pw_req_q   <= 1'b0;
      pw_rstb_q  <= 1'b0;
      pw_rdata_q <= '0;
      underrun_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      // Response byte: an empty FIFO yields FF and leaves the byte phase alone.
      pw_rstb_q <= 1'b0;
      if (pop_d) begin
        pw_rstb_q <= 1'b1;
        if (empty_d) begin
          pw_rdata_q <= 8'hff;
          underrun_q <= 1'b1;
        end else begin
          pw_rdata_q <= head_byte_d;
          phase_q    <= ~phase_q;
        end
      end

      if (push_d) begin
        wr_ptr_q <= wr_ptr_q + CW'(1);
      end
      if (pop_word_d) begin
        rd_ptr_q <= rd_ptr_q + CW'(1);
      end
      if (push_d && !pop_word_d) begin
        count_q <= count_q + (CW+1)'(1);
      end else if (!push_d && pop_word_d) begin
        count_q <= count_q - (CW+1)'(1);
      end

      // Only one burst at a time, so accept and rlast never coincide.
      if (rlast_d) begin
        burst_q <= 1'b0;
      end
      if (accept_d) begin
        burst_q    <= 1'b1;
        mi_valid_q <= 1'b0;
        addr_q     <= addr_q + ADDR_WIDTH'(BURST_LEN);
      end

      case (state_q)
        S_IDLE: begin
          if (rd_cmd_d) begin
            state_q    <= S_ADDR;
            abyte_q    <= '0;
            underrun_q <= 1'b0;
          end
        end

        S_ADDR, S_STREAM: begin
          if (abort_d) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pw_req_q   <= 1'b0;
            mi_valid_q <= 1'b0;
            if (busy_d) begin
              // Wait out the burst in flight; a command byte here is lost.
              state_q <= S_DRAIN;
            end else if (rd_cmd_d) begin
              state_q    <= S_ADDR;
              abyte_q    <= '0;
              underrun_q <= 1'b0;
            end else begin
              state_q <= S_IDLE;
            end
          end else if (state_q == S_ADDR) begin
            if (data_stb_d) begin
              abyte_q <= abyte_q + 2'd1;
              if (abyte_q == 2'd2) begin
                // FIFO is empty and nothing is outstanding, so request at once.
                addr_q     <= start_d[ADDR_WIDTH:1];
                phase_q    <= start_d[0];
                state_q    <= S_STREAM;
                pw_req_q   <= 1'b1;
                mi_valid_q <= 1'b1;
              end else begin
                abuf_q <= {abuf_q[7:0], bus.pw_wdata};
              end
            end
          end else begin
            // Only pops can change occupancy while idle on the bus, so the
            // free-space test stays true until the request is accepted.
            if (!burst_q && !mi_valid_q && free_ok_d) begin
              mi_valid_q <= 1'b1;
            end
          end
        end

        S_DRAIN: begin
          if (rlast_d) begin
            state_q <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_dev_memrd.sv
// tb/tb_spi_dev_memrd.sv - self-checking bench for spi_dev_memrd with a burst memory model
module tb_spi_dev_memrd;

  localparam int AW    = 23;
  localparam int BL    = 8;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_dev_memrd_if #(.ADDR_WIDTH(AW)) bus ();

  spi_dev_memrd #(
    .CMD_BYTE  (8'he1),
    .ADDR_WIDTH(AW),
    .FIFO_DEPTH(DEPTH),
    .BURST_LEN (BL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // session model
  int unsigned cur_base;
  int unsigned cur_idx;
  int unsigned exp_next_addr;
  int          accepts;
  int          words_in;
  bit          track_occ = 1'b0;

  // memory model state
  bit          rsp_active = 1'b0;
  int unsigned rsp_addr;
  int unsigned rsp_idx;
  int unsigned rsp_delay;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Byte i of a stream starting at byte address base, memory word = word address.
  function automatic logic [7:0] exp_byte(input int unsigned base, input int unsigned i);
    int unsigned a;
    int unsigned w;
    logic [15:0] v;
    a = (base + i) & 32'h00ff_ffff;
    w = (a >> 1) & 32'h007f_ffff;
    v = w[15:0];
    return a[0] ? v[7:0] : v[15:8];
  endfunction

  function automatic int consumed();
    return int'(((cur_base & 1) + cur_idx) / 2);
  endfunction

  // Memory controller: random ready, random latency, 8 back-to-back words per burst.
  initial begin
    bit rlast_now;
    bus.mi_ready = 1'b0;
    bus.mi_rstb  = 1'b0;
    bus.mi_rlast = 1'b0;
    bus.mi_rdata = '0;
    forever begin
      @(negedge clk);
      rlast_now = 1'b0;
      if (!rst_n) begin
        rsp_active   = 1'b0;
        bus.mi_rstb  = 1'b0;
        bus.mi_rlast = 1'b0;
        bus.mi_ready = 1'b0;
      end else begin
        bus.mi_rstb  = 1'b0;
        bus.mi_rlast = 1'b0;
        if (rsp_active) begin
          if (rsp_delay > 0) begin
            rsp_delay--;
          end else begin
            bus.mi_rdata = 16'((rsp_addr + rsp_idx) % (1 << AW));
            bus.mi_rstb  = 1'b1;
            words_in++;
            if (track_occ) check("fifo_overflow", 32'((words_in - consumed()) <= DEPTH), 1);
            bus.mi_rlast = (rsp_idx == BL - 1);
            rsp_idx++;
            if (rsp_idx == BL) begin
              rsp_active = 1'b0;
              rlast_now  = 1'b1;
            end
          end
        end
        bus.mi_ready = ($urandom_range(0, 3) != 0);
        if (bus.mi_valid && bus.mi_ready) begin
          check("one_outstanding", 32'(rsp_active || rlast_now), 0);
          check("mi_addr", 32'(bus.mi_addr), exp_next_addr);
          check("mi_len", 32'(bus.mi_len), BL - 1);
          check("mi_rw", 32'(bus.mi_rw), 1);
          if (track_occ) check("free_space", 32'((words_in - consumed()) <= DEPTH - BL), 1);
          rsp_active    = 1'b1;
          rsp_addr      = 32'(bus.mi_addr);
          rsp_idx       = 0;
          rsp_delay     = $urandom_range(1, 4);
          exp_next_addr = (exp_next_addr + BL) % (1 << AW);
          accepts++;
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic cmd, input logic gnt, input logic endx);
    @(negedge clk);
    bus.pw_wdata = d;
    bus.pw_wcmd  = cmd;
    bus.pw_wstb  = 1'b1;
    bus.pw_gnt   = gnt;
    bus.pw_end   = endx;
    @(negedge clk);
    bus.pw_wstb  = 1'b0;
    bus.pw_wcmd  = 1'b0;
    bus.pw_gnt   = 1'b0;
    bus.pw_end   = 1'b0;
  endtask

  task automatic start(input int unsigned baddr);
    cur_base      = baddr & 32'h00ff_ffff;
    cur_idx       = 0;
    words_in      = 0;
    accepts       = 0;
    exp_next_addr = (cur_base >> 1) % (1 << AW);
    send(8'he1, 1'b1, 1'b0, 1'b0);
    send(cur_base[23:16], 1'b0, 1'b0, 1'b0);
    send(cur_base[15:8],  1'b0, 1'b0, 1'b0);
    send(cur_base[7:0],   1'b0, 1'b0, 1'b0);
  endtask

  task automatic dummies();
    for (int i = 0; i < 8; i++) begin
      send(8'h00, 1'b0, 1'b0, 1'b0);
      if (i == 0) check("dummy_no_rstb", 32'(bus.pw_rstb), 0);
      idle(2);
    end
  endtask

  task automatic pop_check(input int n);
    for (int i = 0; i < n; i++) begin
      send(8'h00, 1'b0, 1'b1, 1'b0);
      check("pop_rstb", 32'(bus.pw_rstb), 1);
      check("pop_rdata", 32'(bus.pw_rdata), 32'(exp_byte(cur_base, cur_idx)));
      cur_idx++;
      idle(2);
    end
  endtask

  task automatic end_pulse();
    @(negedge clk);
    bus.pw_end = 1'b1;
    @(negedge clk);
    bus.pw_end = 1'b0;
    check("req_drop_on_end", 32'(bus.pw_req), 0);
  endtask

  task automatic wait_quiet();
    int n = 0;
    while ((rsp_active || bus.mi_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("quiet_timeout", 32'(n < 400), 1);
    idle(2);
  endtask

  initial begin
    int unsigned ra;
    int n;
    int calm;
    bus.pw_wdata = '0;
    bus.pw_wcmd  = 1'b0;
    bus.pw_wstb  = 1'b0;
    bus.pw_end   = 1'b0;
    bus.pw_gnt   = 1'b0;

    // reset values
    idle(3);
    check("rst_mi_valid", 32'(bus.mi_valid), 0);
    check("rst_mi_rw", 32'(bus.mi_rw), 1);
    check("rst_mi_len", 32'(bus.mi_len), BL - 1);
    check("rst_mi_addr", 32'(bus.mi_addr), 0);
    check("rst_pw_req", 32'(bus.pw_req), 0);
    check("rst_pw_rstb", 32'(bus.pw_rstb), 0);
    check("rst_underrun", 32'(bus.underrun), 0);
    rst_n = 1'b1;
    idle(2);

    // even start: E1 00 00 10 -> words 8,9,10
    start(32'h10);
    check("stream_req", 32'(bus.pw_req), 1);
    dummies();
    pop_check(6);
    end_pulse();
    wait_quiet();

    // odd start skips the first high byte
    start(32'h11);
    dummies();
    pop_check(3);
    end_pulse();
    wait_quiet();

    // long stream from 0 with free-space and overflow tracking
    track_occ = 1'b1;
    start(32'h0);
    dummies();
    pop_check(80);
    check("stream_bursts", 32'(accepts >= 5), 1);
    track_occ = 1'b0;
    end_pulse();
    wait_quiet();

    // address wraps to 0 after word 0x7FFFF8
    start(32'hff_fff0);
    n = 0;
    while (accepts < 2 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("wrap_two_bursts", 32'(accepts >= 2), 1);
    dummies();
    pop_check(4);
    end_pulse();
    wait_quiet();

    // random sessions, each closed by a pop colliding with pw_end
    for (int s = 0; s < 4; s++) begin
      ra = $urandom & 32'h00ff_ffff;
      start(ra);
      dummies();
      pop_check($urandom_range(1, 20));
      send(8'h00, 1'b0, 1'b1, 1'b1);
      check("end_pop_no_rstb", 32'(bus.pw_rstb), 0);
      check("end_pop_req", 32'(bus.pw_req), 0);
      wait_quiet();
    end

    // pw_end mid-burst -> DRAIN; E1 during DRAIN is dropped
    start(32'h40);
    n = 0;
    while (!(rsp_active && rsp_idx >= 1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_burst_seen", 32'(rsp_active && rsp_idx >= 1), 1);
    end_pulse();
    send(8'he1, 1'b1, 1'b0, 1'b0);
    check("drain_no_rstb", 32'(bus.pw_rstb), 0);
    wait_quiet();
    send(8'h00, 1'b0, 1'b0, 1'b0);
    send(8'h00, 1'b0, 1'b0, 1'b0);
    send(8'h20, 1'b0, 1'b0, 1'b0);
    idle(2);
    check("drain_cmd_dropped_req", 32'(bus.pw_req), 0);
    check("drain_cmd_dropped_valid", 32'(bus.mi_valid), 0);

    // underrun on a pop straight after the address
    start(32'h100);
    send(8'h00, 1'b0, 1'b1, 1'b0);
    check("underrun_rstb", 32'(bus.pw_rstb), 1);
    check("underrun_rdata", 32'(bus.pw_rdata), 32'h0ff);
    check("underrun_flag", 32'(bus.underrun), 1);
    n = 0;
    calm = 0;
    while (calm < 20 && n < 600) begin
      @(negedge clk);
      n++;
      if (rsp_active || bus.mi_valid) calm = 0;
      else calm++;
    end
    check("fifo_fill_timeout", 32'(calm >= 20), 1);
    start(32'h200);
    check("underrun_cleared", 32'(bus.underrun), 0);
    check("restart_req", 32'(bus.pw_req), 1);
    send(8'h00, 1'b0, 1'b1, 1'b0);
    check("underrun_again", 32'(bus.underrun), 1);

    // asynchronous reset with a burst outstanding
    n = 0;
    while (!rsp_active && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reset_burst_seen", 32'(rsp_active), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_mi_valid", 32'(bus.mi_valid), 0);
    check("arst_mi_addr", 32'(bus.mi_addr), 0);
    check("arst_mi_len", 32'(bus.mi_len), BL - 1);
    check("arst_mi_rw", 32'(bus.mi_rw), 1);
    check("arst_pw_req", 32'(bus.pw_req), 0);
    check("arst_pw_rdata", 32'(bus.pw_rdata), 0);
    check("arst_pw_rstb", 32'(bus.pw_rstb), 0);
    check("arst_underrun", 32'(bus.underrun), 0);
    idle(3);
    rst_n = 1'b1;
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
